// File: rtl/serial_adder.sv
// Multi-cycle adder/subtractor: consumes DIGIT bits per clock, LSB digit first,
// through a registered carry; reports sum, carry-out and signed overflow with a done pulse.
module serial_adder #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] ip1,
  input  logic [WIDTH-1:0] ip2,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             ovf
);

  localparam int NSTEP = WIDTH / DIGIT;
  localparam int SW = $clog2(NSTEP + 1);
  localparam logic [SW-1:0] LAST = SW'(NSTEP - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t                 state;
  logic [WIDTH-1:0]       a_q;
  logic [WIDTH-1:0]       b_q;
  logic [WIDTH-1:0]       acc_q;
  logic                   c_q;
  logic [SW-1:0]          step_q;

  logic [DIGIT:0]         dsum;
  logic [WIDTH+DIGIT-1:0] acc_cat;
  logic [WIDTH-1:0]       acc_next;
  logic                   msb_cin;

  // Carry into the top bit of the digit is recovered from sum ^ a ^ b, which
  // on the final digit is the carry into bit WIDTH-1.
  always_comb begin
    dsum     = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]} + {{DIGIT{1'b0}}, c_q};
    acc_cat  = {dsum[DIGIT-1:0], acc_q};
    acc_next = acc_cat[WIDTH+DIGIT-1:DIGIT];
    msb_cin  = dsum[DIGIT-1] ^ a_q[DIGIT-1] ^ b_q[DIGIT-1];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      a_q    <= '0;
      b_q    <= '0;
      acc_q  <= '0;
      c_q    <= 1'b0;
      step_q <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      sum    <= '0;
      carry  <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_q    <= ip1;
            b_q    <= sub ? ~ip2 : ip2;
            c_q    <= sub ? 1'b1 : cin;
            step_q <= '0;
            busy   <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          acc_q  <= acc_next;
          c_q    <= dsum[DIGIT];
          a_q    <= a_q >> DIGIT;
          b_q    <= b_q >> DIGIT;
          step_q <= step_q + 1'b1;
          if (step_q == LAST) begin
            sum   <= acc_next;
            carry <= dsum[DIGIT];
            ovf   <= msb_cin ^ dsum[DIGIT];
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: directed vectors on an 8/1 instance plus a random
// add/sub sweep on 8/4, 8/8 and 16/2 instances, all checked through a scoreboard.
module tb_serial_adder;

  localparam int EW = 50;  // {expected done cycle[31:0], ovf, carry, sum[15:0]}

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // main 8-bit, 1-bit-digit instance
  logic       start, sub, cin, busy, done, carry, ovf;
  logic [7:0] ip1, ip2, sum;

  // sweep instances share stimulus
  logic        s_start, s_sub, s_cin;
  logic [15:0] s_ip1, s_ip2;
  logic        busy4, done4, carry4, ovf4;
  logic        busy8, done8, carry8, ovf8;
  logic        busy16, done16, carry16, ovf16;
  logic [7:0]  sum4, sum8;
  logic [15:0] sum16;

  logic [EW-1:0] exp_q0[$];
  logic [EW-1:0] exp_q4[$];
  logic [EW-1:0] exp_q8[$];
  logic [EW-1:0] exp_q16[$];

  serial_adder #(.WIDTH(8), .DIGIT(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .ip1(ip1), .ip2(ip2), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .carry(carry), .ovf(ovf)
  );

  serial_adder #(.WIDTH(8), .DIGIT(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(s_start), .sub(s_sub), .ip1(s_ip1[7:0]), .ip2(s_ip2[7:0]),
    .cin(s_cin), .busy(busy4), .done(done4), .sum(sum4), .carry(carry4), .ovf(ovf4)
  );

  serial_adder #(.WIDTH(8), .DIGIT(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(s_start), .sub(s_sub), .ip1(s_ip1[7:0]), .ip2(s_ip2[7:0]),
    .cin(s_cin), .busy(busy8), .done(done8), .sum(sum8), .carry(carry8), .ovf(ovf8)
  );

  serial_adder #(.WIDTH(16), .DIGIT(2)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(s_start), .sub(s_sub), .ip1(s_ip1), .ip2(s_ip2),
    .cin(s_cin), .busy(busy16), .done(done16), .sum(sum16), .carry(carry16), .ovf(ovf16)
  );

  // Reference: plain wide addition; overflow from operand/result sign rule.
  function automatic logic [17:0] ref_model(input int w, input logic [15:0] a, input logic [15:0] b,
                                            input logic ci, input logic sb);
    logic [15:0] m, am, bm, s;
    logic [16:0] full;
    logic        co, ov;
    m    = (w == 16) ? 16'hFFFF : 16'h00FF;
    am   = a & m;
    bm   = (sb ? ~b : b) & m;
    full = {1'b0, am} + {1'b0, bm} + {16'h0, (sb ? 1'b1 : ci)};
    s    = full[15:0] & m;
    co   = (w == 16) ? full[16] : full[8];
    ov   = (am[w-1] == bm[w-1]) && (s[w-1] != am[w-1]);
    return {ov, co, s};
  endfunction

  task automatic compare(input string nm, input logic [EW-1:0] e, input logic [15:0] s,
                         input logic co, input logic ov);
    checks++;
    if ({ov, co, s} !== e[17:0]) begin
      errors++;
      $display("FAIL %s result: got sum=%h carry=%b ovf=%b, expected sum=%h carry=%b ovf=%b",
               nm, s, co, ov, e[15:0], e[16], e[17]);
    end
    checks++;
    if (cyc !== int'(e[49:18])) begin
      errors++;
      $display("FAIL %s latency: done at cycle %0d, expected cycle %0d", nm, cyc, e[49:18]);
    end
  endtask

  task automatic unexpected(input string nm);
    checks++;
    errors++;
    $display("FAIL %s unexpected_done: got done=1 at cycle %0d, expected no result pending", nm, cyc);
  endtask

  // Monitors: pop and compare whenever a done pulse is presented.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (exp_q0.size() == 0) unexpected("u0");
      else compare("u0", exp_q0.pop_front(), {8'h00, sum}, carry, ovf);
    end
    if (done4 === 1'b1) begin
      if (exp_q4.size() == 0) unexpected("u4");
      else compare("u4", exp_q4.pop_front(), {8'h00, sum4}, carry4, ovf4);
    end
    if (done8 === 1'b1) begin
      if (exp_q8.size() == 0) unexpected("u8");
      else compare("u8", exp_q8.pop_front(), {8'h00, sum8}, carry8, ovf8);
    end
    if (done16 === 1'b1) begin
      if (exp_q16.size() == 0) unexpected("u16");
      else compare("u16", exp_q16.pop_front(), sum16, carry16, ovf16);
    end
  end

  // Called at a negedge; start is accepted at the following posedge.
  task automatic issue0(input logic [7:0] a, input logic [7:0] b, input logic ci, input logic sb,
                        input logic [7:0] es, input logic ec, input logic eo);
    ip1   = a;
    ip2   = b;
    cin   = ci;
    sub   = sb;
    start = 1'b1;
    exp_q0.push_back({32'(cyc + 1 + 8), eo, ec, 8'h00, es});
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done0(input string nm, input int exp_busy, input bit chk_hold,
                            input logic [7:0] hold);
    int n;
    bit seen;
    n = 0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (done === 1'b1) begin
        seen = 1'b1;
        break;
      end
      if (busy === 1'b1) n++;
      if (chk_hold) begin
        checks++;
        if (sum !== hold) begin
          errors++;
          $display("FAIL %s sum_hold: got %h during run, expected %h", nm, sum, hold);
        end
      end
      @(negedge clk);
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s timeout: got no done within 20 cycles, expected done", nm);
    end
    checks++;
    if (n != exp_busy) begin
      errors++;
      $display("FAIL %s busy_len: got %0d busy cycles, expected %0d", nm, n, exp_busy);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s busy_at_done: got %b, expected 0", nm, busy);
    end
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] a, b;
    logic        ci, sb;
    int          k;

    rst_n = 1'b0; start = 1'b0; sub = 1'b0; cin = 1'b0; ip1 = '0; ip2 = '0;
    s_start = 1'b0; s_sub = 1'b0; s_cin = 1'b0; s_ip1 = '0; s_ip2 = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({sum, carry, ovf, busy, done} !== 12'h000) begin
      errors++;
      $display("FAIL reset_state: got sum=%h carry=%b ovf=%b busy=%b done=%b, expected all 0",
               sum, carry, ovf, busy, done);
    end
    rst_n = 1'b1;
    @(negedge clk);

    // Add with signed overflow
    issue0(8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0, 1'b1);
    wait_done0("add_ovf", 8, 1'b1, 8'h00);
    // Add with carry in and carry out
    issue0(8'hFF, 8'h01, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0);
    wait_done0("add_cin", 8, 1'b0, 8'h00);
    // Subtract with borrow; cin ignored
    issue0(8'h10, 8'h20, 1'b1, 1'b1, 8'hF0, 1'b0, 1'b0);
    wait_done0("sub_borrow", 8, 1'b0, 8'h00);
    // Subtract with signed overflow
    issue0(8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1);
    wait_done0("sub_ovf", 8, 1'b0, 8'h00);

    // Start pulsed mid-run must be ignored; sum holds previous result
    issue0(8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0, 1'b0);
    @(negedge clk);
    ip1 = 8'hAA; ip2 = 8'h55; sub = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done0("mid_start", 6, 1'b1, 8'h7F);
    repeat (12) @(negedge clk);

    // Back-to-back: second start issued in the done cycle
    issue0(8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
    wait_done0("b2b_first", 8, 1'b0, 8'h00);
    issue0(8'hC0, 8'hC0, 1'b0, 1'b0, 8'h80, 1'b1, 1'b0);
    wait_done0("b2b_second", 8, 1'b1, 8'h80);
    @(negedge clk);

    // Reset mid-run, with start held high during reset
    issue0(8'h33, 8'h44, 1'b0, 1'b0, 8'h77, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    start = 1'b1;
    ip1 = 8'h77;
    exp_q0.delete();
    @(negedge clk);
    checks++;
    if ({sum, carry, ovf, busy, done} !== 12'h000) begin
      errors++;
      $display("FAIL reset_abort: got sum=%h carry=%b ovf=%b busy=%b done=%b, expected all 0",
               sum, carry, ovf, busy, done);
    end
    rst_n = 1'b1;
    issue0(8'h01, 8'h01, 1'b0, 1'b0, 8'h02, 1'b0, 1'b0);
    wait_done0("after_reset", 8, 1'b1, 8'h00);
    repeat (4) @(negedge clk);

    // Random add/sub sweep across digit sizes
    for (int n = 0; n < 1000; n++) begin
      a  = 16'($urandom);
      b  = 16'($urandom);
      ci = 1'($urandom_range(0, 1));
      sb = 1'($urandom_range(0, 1));
      s_ip1 = a; s_ip2 = b; s_cin = ci; s_sub = sb; s_start = 1'b1;
      exp_q4.push_back({32'(cyc + 1 + 2), ref_model(8, a, b, ci, sb)});
      exp_q8.push_back({32'(cyc + 1 + 1), ref_model(8, a, b, ci, sb)});
      exp_q16.push_back({32'(cyc + 1 + 8), ref_model(16, a, b, ci, sb)});
      @(negedge clk);
      s_start = 1'b0;
      k = 0;
      while ((busy4 || busy8 || busy16) && k < 20) begin
        @(negedge clk);
        k++;
      end
      if (k >= 20) begin
        checks++;
        errors++;
        $display("FAIL sweep_timeout: got busy after 20 cycles, expected idle (op %0d)", n);
      end
    end
    repeat (4) @(negedge clk);

    checks++;
    if (exp_q0.size() + exp_q4.size() + exp_q8.size() + exp_q16.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d/%0d/%0d/%0d results outstanding, expected 0",
               exp_q0.size(), exp_q4.size(), exp_q8.size(), exp_q16.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
